// File: rtl/bpred_table_sched_pkg.sv
// ---------------------------------------------------------------------------
// cvw_bpsched_pkg
// Shared types for the branch-predictor table port scheduler.
//   bpsched_state_t : scheduler FSM state (CLEAR walk / RUN arbitration)
//   bpsched_upd_t   : training-update entry {idx, data} at the default
//                     table geometry (1024 entries x 2 bits). The modules
//                     build the same {idx, data} layout at their own
//                     parameterised widths.
// ---------------------------------------------------------------------------
package cvw_bpsched_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } bpsched_state_t;

    localparam int BPSCHED_IDX_BITS = 10;
    localparam int BPSCHED_DATA_W   = 2;

    typedef struct packed {
        logic [BPSCHED_IDX_BITS-1:0] idx;
        logic [BPSCHED_DATA_W-1:0]   data;
    } bpsched_upd_t;

endpackage

// File: rtl/bpred_table_sched_upd_fifo.sv
// ---------------------------------------------------------------------------
// bpred_upd_fifo
// Training-update queue for the predictor table scheduler. Holds pending
// {idx, data} writes in FIFO order, merges a new update into the tail entry
// when both target the same index, and (with BPRED_SCHED_BYPASS_EN) searches
// the queue for the youngest entry matching a lookup index.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   flush                 drop every pending entry (takes priority)
//   enq, enqIdx, enqData  accepted update (caller guarantees ~full)
//   deq                   head entry is written to RAM this cycle
//   headIdx, headData     oldest entry
//   empty, full, count    occupancy
//   searchIdx/Hit/Data    bypass search (BPRED_SCHED_BYPASS_EN only)
// ---------------------------------------------------------------------------
module bpred_upd_fifo
    import cvw_bpsched_pkg::*;
#(
    parameter int IDX_BITS = 10,
    parameter int DATA_W   = 2,
    parameter int QDEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         enq,
    input  logic [IDX_BITS-1:0]          enqIdx,
    input  logic [DATA_W-1:0]            enqData,
    input  logic                         deq,
    output logic [IDX_BITS-1:0]          headIdx,
    output logic [DATA_W-1:0]            headData,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(QDEPTH):0]      count
`ifdef BPRED_SCHED_BYPASS_EN
    ,
    input  logic [IDX_BITS-1:0]          searchIdx,
    output logic                         searchHit,
    output logic [DATA_W-1:0]            searchData
`endif
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [IDX_BITS-1:0] idx;
        logic [DATA_W-1:0]   data;
    } updEntry_t;

    updEntry_t        mem [QDEPTH];
    logic [PTR_W-1:0] rdPtr, wrPtr, tailPtr;
    logic [CNT_W-1:0] cnt;
    logic             tailDeq, coalesce, push;

    assign empty    = (cnt == '0);
    assign full     = (cnt == CNT_W'(QDEPTH));
    assign count    = cnt;
    assign headIdx  = mem[rdPtr].idx;
    assign headData = mem[rdPtr].data;
    assign tailPtr  = wrPtr - PTR_W'(1);

    // The tail can only be merged into if it survives this cycle; a lone
    // entry that is being written out must be followed by a fresh entry.
    assign tailDeq  = deq & (cnt == CNT_W'(1));
    assign coalesce = enq & ~empty & ~tailDeq & (mem[tailPtr].idx == enqIdx);
    assign push     = enq & ~coalesce;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            cnt   <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (deq)  rdPtr <= rdPtr + PTR_W'(1);
            case ({push, deq})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr].idx  <= enqIdx;
            mem[wrPtr].data <= enqData;
        end else if (coalesce) begin
            mem[tailPtr].data <= enqData;
        end
    end

`ifdef BPRED_SCHED_BYPASS_EN
    // Walk oldest to youngest so the last match wins; the update arriving
    // this cycle is younger than anything stored.
    always_comb begin
        logic [PTR_W-1:0] slot;
        slot       = rdPtr;
        searchHit  = 1'b0;
        searchData = '0;
        for (int k = 0; k < QDEPTH; k++) begin
            slot = rdPtr + PTR_W'(k);
            if ((CNT_W'(k) < cnt) && (mem[slot].idx == searchIdx)) begin
                searchHit  = 1'b1;
                searchData = mem[slot].data;
            end
        end
        if (enq && (enqIdx == searchIdx)) begin
            searchHit  = 1'b1;
            searchData = enqData;
        end
    end
`endif

endmodule

// File: rtl/bpred_table_sched.sv
// ---------------------------------------------------------------------------
// bpred_table_sched
// Single-port SRAM scheduler for a branch-predictor table. Fetch lookups and
// buffered training updates share the one RAM port; updates win when the
// fetch stage is idle, when the queue is full, or after STARVE_LIMIT
// consecutive denied cycles. After reset and on ClearReq the whole table is
// walked and written to zero.
//
// Optional feature macro: BPRED_SCHED_BYPASS_EN
//   Adds LookupFwdHitF / LookupFwdDataF, a registered forward of the youngest
//   queued update matching LookupIdxF, aligned with the RAM read latency.
//
// Ports
//   clk, reset                        clock, synchronous active-high reset
//   ClearReq / ClearBusy              clear request pulse / walk in progress
//   LookupValidF, LookupIdxF          fetch read request
//   LookupGrantF                      read issued to RAM this cycle
//   UpdValidM, UpdIdxM, UpdDataM      training update offer
//   UpdReadyM                         update accepted when valid & ready
//   TblEn, TblWe, TblIdx, TblWData    RAM port
//   QCount                            update queue occupancy
// ---------------------------------------------------------------------------
// state | meaning
// ------+-------------------------------------------------------------------
// CLEAR | writing zero at ClrIdx each cycle; no lookups, no updates accepted
// RUN   | arbitrating lookups vs. queued updates, one RAM access per cycle
// ---------------------------------------------------------------------------
module bpred_table_sched
    import cvw_bpsched_pkg::*;
#(
    parameter int IDX_BITS     = 10,
    parameter int DATA_W       = 2,
    parameter int QDEPTH       = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ClearReq,
    output logic                         ClearBusy,
    input  logic                         LookupValidF,
    input  logic [IDX_BITS-1:0]          LookupIdxF,
    output logic                         LookupGrantF,
    input  logic                         UpdValidM,
    input  logic [IDX_BITS-1:0]          UpdIdxM,
    input  logic [DATA_W-1:0]            UpdDataM,
    output logic                         UpdReadyM,
    output logic                         TblEn,
    output logic                         TblWe,
    output logic [IDX_BITS-1:0]          TblIdx,
    output logic [DATA_W-1:0]            TblWData,
    output logic [$clog2(QDEPTH):0]      QCount
`ifdef BPRED_SCHED_BYPASS_EN
    ,
    output logic                         LookupFwdHitF,
    output logic [DATA_W-1:0]            LookupFwdDataF
`endif
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [IDX_BITS-1:0] LAST_IDX = '1;

    bpsched_state_t      state, stateNext;
    logic [IDX_BITS-1:0] clrIdx, clrIdxNext;
    logic [STARVE_W-1:0] starveCnt, starveNext;
    logic                qEmpty, qFull, forceUpd, enq, deq;
    logic [IDX_BITS-1:0] headIdx;
    logic [DATA_W-1:0]   headData;

    assign ClearBusy = (state == CLEAR);
    assign forceUpd  = qFull | (starveCnt == STARVE_W'(STARVE_LIMIT));
    // A full queue refuses even when it drains this cycle; this keeps the
    // ready path independent of the arbitration result.
    assign UpdReadyM = (state == RUN) & ~qFull & ~ClearReq;
    assign enq       = UpdValidM & UpdReadyM;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLEAR;
            clrIdx    <= '0;
            starveCnt <= '0;
        end else begin
            state     <= stateNext;
            clrIdx    <= clrIdxNext;
            starveCnt <= starveNext;
        end
    end

    always_comb begin
        stateNext    = state;
        clrIdxNext   = clrIdx;
        starveNext   = starveCnt;
        TblEn        = 1'b0;
        TblWe        = 1'b0;
        TblIdx       = '0;
        TblWData     = '0;
        LookupGrantF = 1'b0;
        deq          = 1'b0;

        case (state)
            CLEAR: begin
                TblEn      = 1'b1;
                TblWe      = 1'b1;
                TblIdx     = clrIdx;
                clrIdxNext = clrIdx + IDX_BITS'(1);
                starveNext = '0;
                if (clrIdx == LAST_IDX) stateNext = RUN;
            end
            RUN: begin
                if (!qEmpty && (forceUpd || !LookupValidF)) begin
                    TblEn    = 1'b1;
                    TblWe    = 1'b1;
                    TblIdx   = headIdx;
                    TblWData = headData;
                    deq      = 1'b1;
                end else if (LookupValidF) begin
                    TblEn        = 1'b1;
                    TblIdx       = LookupIdxF;
                    LookupGrantF = 1'b1;
                end

                // Non-empty and not dequeued means a lookup took the port.
                if (deq || qEmpty)
                    starveNext = '0;
                else if (starveCnt != STARVE_W'(STARVE_LIMIT))
                    starveNext = starveCnt + STARVE_W'(1);
            end
            default: stateNext = CLEAR;
        endcase

        // The current cycle's RAM access still goes out; only the next
        // state is redirected into a fresh walk.
        if (ClearReq) begin
            stateNext  = CLEAR;
            clrIdxNext = '0;
            starveNext = '0;
        end
    end

`ifdef BPRED_SCHED_BYPASS_EN
    logic              fwdHit;
    logic [DATA_W-1:0] fwdData;
`endif

    bpred_upd_fifo #(
        .IDX_BITS (IDX_BITS),
        .DATA_W   (DATA_W),
        .QDEPTH   (QDEPTH)
    ) u_updFifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (ClearReq),
        .enq      (enq),
        .enqIdx   (UpdIdxM),
        .enqData  (UpdDataM),
        .deq      (deq),
        .headIdx  (headIdx),
        .headData (headData),
        .empty    (qEmpty),
        .full     (qFull),
        .count    (QCount)
`ifdef BPRED_SCHED_BYPASS_EN
        ,
        .searchIdx  (LookupIdxF),
        .searchHit  (fwdHit),
        .searchData (fwdData)
`endif
    );

`ifdef BPRED_SCHED_BYPASS_EN
    // Entries about to be flushed must not be forwarded into the clear walk.
    always_ff @(posedge clk) begin
        if (reset) begin
            LookupFwdHitF  <= 1'b0;
            LookupFwdDataF <= '0;
        end else begin
            LookupFwdHitF  <= fwdHit & (state == RUN) & ~ClearReq;
            LookupFwdDataF <= fwdData;
        end
    end
`endif

endmodule

// File: tb/tb_bpred_table_sched.sv
// ---------------------------------------------------------------------------
// tb_bpred_table_sched
// Self-checking bench for bpred_table_sched (IDX_BITS=4, QDEPTH=4,
// STARVE_LIMIT=3). Accepted updates push their expected RAM write onto a
// scoreboard queue; a negedge monitor pops and compares every RUN-state
// write. Define BPRED_SCHED_BYPASS_EN to also exercise the forward path.
// ---------------------------------------------------------------------------
module tb_bpred_table_sched;

    localparam int IW = 4;
    localparam int DW = 2;
    localparam int QD = 4;
    localparam int SL = 3;
    localparam int CW = $clog2(QD) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          ClearReq;
    logic          ClearBusy;
    logic          LookupValidF;
    logic [IW-1:0] LookupIdxF;
    logic          LookupGrantF;
    logic          UpdValidM;
    logic [IW-1:0] UpdIdxM;
    logic [DW-1:0] UpdDataM;
    logic          UpdReadyM;
    logic          TblEn;
    logic          TblWe;
    logic [IW-1:0] TblIdx;
    logic [DW-1:0] TblWData;
    logic [CW-1:0] QCount;
`ifdef BPRED_SCHED_BYPASS_EN
    logic          LookupFwdHitF;
    logic [DW-1:0] LookupFwdDataF;
`endif

    always #5 clk = ~clk;

    bpred_table_sched #(
        .IDX_BITS     (IW),
        .DATA_W       (DW),
        .QDEPTH       (QD),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ClearReq     (ClearReq),
        .ClearBusy    (ClearBusy),
        .LookupValidF (LookupValidF),
        .LookupIdxF   (LookupIdxF),
        .LookupGrantF (LookupGrantF),
        .UpdValidM    (UpdValidM),
        .UpdIdxM      (UpdIdxM),
        .UpdDataM     (UpdDataM),
        .UpdReadyM    (UpdReadyM),
        .TblEn        (TblEn),
        .TblWe        (TblWe),
        .TblIdx       (TblIdx),
        .TblWData     (TblWData),
        .QCount       (QCount)
`ifdef BPRED_SCHED_BYPASS_EN
        ,
        .LookupFwdHitF  (LookupFwdHitF),
        .LookupFwdDataF (LookupFwdDataF)
`endif
    );

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [DW-1:0] data;
    } wr_t;

    wr_t expQ[$];
    int  checks = 0;
    int  errors = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every write outside the clear walk must be the
    // next expected update.
    always @(negedge clk) begin
        wr_t e;
        if (!reset && TblEn && TblWe && !ClearBusy) begin
            if (expQ.size() == 0) begin
                checkVal("spurious-write", TblWe, 1'b0);
            end else begin
                e = expQ.pop_front();
                checkVal("wr-idx", TblIdx, e.idx);
                checkVal("wr-data", TblWData, e.data);
            end
        end
    end

    task automatic offer(input logic [IW-1:0] i, input logic [DW-1:0] d, input bit accept);
        wr_t e;
        UpdValidM = 1'b1;
        UpdIdxM   = i;
        UpdDataM  = d;
        if (accept) begin
            e.idx  = i;
            e.data = d;
            expQ.push_back(e);
        end
    endtask

    task automatic cyc(input string tag, input logic expGrant, input logic expReady,
                       input logic [CW-1:0] expQc);
        @(negedge clk);
        checkVal({tag, "-grant"}, LookupGrantF, expGrant);
        checkVal({tag, "-ready"}, UpdReadyM, expReady);
        checkVal({tag, "-qcount"}, QCount, expQc);
        @(posedge clk);
        #1;
    endtask

    task automatic clearWalk(input string tag, input int start, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkVal({tag, "-busy"}, ClearBusy, 1'b1);
            checkVal({tag, "-en"}, TblEn, 1'b1);
            checkVal({tag, "-we"}, TblWe, 1'b1);
            checkVal({tag, "-idx"}, TblIdx, 32'(start + i));
            checkVal({tag, "-wdata"}, TblWData, '0);
            checkVal({tag, "-grant"}, LookupGrantF, 1'b0);
            checkVal({tag, "-ready"}, UpdReadyM, 1'b0);
            checkVal({tag, "-qcount"}, QCount, '0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic walkDone(input string tag);
        @(negedge clk);
        checkVal({tag, "-busy"}, ClearBusy, 1'b0);
        checkVal({tag, "-ready"}, UpdReadyM, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        LookupValidF = 1'b0;
        UpdValidM    = 1'b0;
        n = 0;
        @(negedge clk);
        while (QCount != '0 && n < 12) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            n++;
        end
        checkVal({tag, "-drained"}, QCount, '0);
        checkVal({tag, "-sb-empty"}, expQ.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        ClearReq     = 1'b0;
        LookupValidF = 1'b0;
        LookupIdxF   = '0;
        UpdValidM    = 1'b0;
        UpdIdxM      = '0;
        UpdDataM     = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Post-reset clear walk; lookups offered but must not be granted.
        LookupValidF = 1'b1;
        LookupIdxF   = 4'hA;
        clearWalk("rst", 0, 16);
        walkDone("rst-done");

        // Starvation: two updates behind continuous lookups.
        LookupIdxF = 4'd1;
        offer(4'd5, 2'd1, 1'b1);  cyc("st0", 1'b1, 1'b1, 3'd0);
        offer(4'd9, 2'd2, 1'b1);  cyc("st1", 1'b1, 1'b1, 3'd1);
        UpdValidM = 1'b0;
        cyc("st2", 1'b1, 1'b1, 3'd2);
        cyc("st3", 1'b1, 1'b1, 3'd2);
        cyc("st4", 1'b0, 1'b1, 3'd2);
        cyc("st5", 1'b1, 1'b1, 3'd1);
        cyc("st6", 1'b1, 1'b1, 3'd1);
        cyc("st7", 1'b1, 1'b1, 3'd1);
        cyc("st8", 1'b0, 1'b1, 3'd1);
        drain("st");

        // Queue full: refusal while full, and a write forced by fullness
        // alone (starvation count is only 1 at fu6).
        LookupValidF = 1'b1;
        offer(4'd1, 2'd1, 1'b1);  cyc("fu0", 1'b1, 1'b1, 3'd0);
        offer(4'd2, 2'd2, 1'b1);  cyc("fu1", 1'b1, 1'b1, 3'd1);
        offer(4'd3, 2'd3, 1'b1);  cyc("fu2", 1'b1, 1'b1, 3'd2);
        offer(4'd4, 2'd0, 1'b1);  cyc("fu3", 1'b1, 1'b1, 3'd3);
        offer(4'd8, 2'd1, 1'b0);  cyc("fu4", 1'b0, 1'b0, 3'd4);
        offer(4'd6, 2'd1, 1'b1);  cyc("fu5", 1'b1, 1'b1, 3'd3);
        offer(4'd9, 2'd3, 1'b0);  cyc("fu6", 1'b0, 1'b0, 3'd4);
        drain("fu");

        // Tail coalescing while the port is busy with lookups.
        LookupValidF = 1'b1;
        offer(4'd7, 2'd1, 1'b0);  cyc("co0", 1'b1, 1'b1, 3'd0);
        offer(4'd7, 2'd3, 1'b1);  cyc("co1", 1'b1, 1'b1, 3'd1);
        UpdValidM = 1'b0;
        cyc("co2", 1'b1, 1'b1, 3'd1);
        cyc("co3", 1'b1, 1'b1, 3'd1);
        cyc("co4", 1'b0, 1'b1, 3'd1);
        drain("co");

        // Same index as a tail that is being written out: no merge.
        LookupValidF = 1'b1;
        offer(4'd10, 2'd1, 1'b1); cyc("nc0", 1'b1, 1'b1, 3'd0);
        LookupValidF = 1'b0;
        offer(4'd10, 2'd2, 1'b1); cyc("nc1", 1'b0, 1'b1, 3'd1);
        UpdValidM = 1'b0;
        cyc("nc2", 1'b0, 1'b1, 3'd1);
        drain("nc");

        // ClearReq in RUN with three pending updates: they are dropped.
        LookupValidF = 1'b1;
        offer(4'd1, 2'd1, 1'b0);  cyc("cr0", 1'b1, 1'b1, 3'd0);
        offer(4'd2, 2'd2, 1'b0);  cyc("cr1", 1'b1, 1'b1, 3'd1);
        offer(4'd3, 2'd3, 1'b0);  cyc("cr2", 1'b1, 1'b1, 3'd2);
        offer(4'd4, 2'd0, 1'b0);
        ClearReq = 1'b1;
        cyc("cr3", 1'b1, 1'b0, 3'd3);
        ClearReq  = 1'b0;
        UpdValidM = 1'b0;
        clearWalk("clr1", 0, 6);
        ClearReq = 1'b1;
        clearWalk("clr1-re", 6, 1);
        ClearReq = 1'b0;
        clearWalk("clr2", 0, 16);
        walkDone("clr2-done");

`ifdef BPRED_SCHED_BYPASS_EN
        // Forward of an update enqueued in the same cycle as the lookup.
        LookupValidF = 1'b1;
        LookupIdxF   = 4'd2;
        offer(4'd2, 2'd2, 1'b1);
        cyc("by0", 1'b1, 1'b1, 3'd0);
        UpdValidM  = 1'b0;
        LookupIdxF = 4'd3;
        @(negedge clk);
        checkVal("by1-hit", LookupFwdHitF, 1'b1);
        checkVal("by1-data", LookupFwdDataF, 2'd2);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkVal("by2-hit", LookupFwdHitF, 1'b0);
        @(posedge clk);
        #1;
        drain("by");
`endif

        checkVal("sb-final", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
